// File: rtl/pingpong_unpack_if.sv
// Handshake bundle for pingpong_unpack: 16-bit word input stream and 8-bit byte
// output stream, plus bank status.
interface pingpong_unpack_if;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [1:0]  bank_full;
   logic [7:0]  frame_count;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, bank_full, frame_count
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, bank_full, frame_count
   );
endinterface

// File: rtl/pingpong_unpack.sv
// Two-bank ping-pong buffer: one bank fills with 16-bit words while the other
// drains as a low-byte-first 8-bit stream.
module pingpong_unpack #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   pingpong_unpack_if.slave  bus
);
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_LO, R_HI} rstate_e;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [15:0]   mem [2*DEPTH];
   logic [15:0]   word_q;
   rstate_e       state_q;
   logic          wbank_q, rbank_q;
   logic [AW-1:0] waddr_q, raddr_q;
   logic [1:0]    bank_full_q, bank_full_d, set_full, clr_full;
   logic [7:0]    out_data_q, frame_count_q;
   logic          out_valid_q, out_last_q;
   logic          wr_acc, out_acc, last_word, rd_en;
   logic [AW:0]   rd_addr;

   assign bus.in_ready    = !reset && !bank_full_q[wbank_q];
   assign bus.out_data    = out_data_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_last    = out_last_q;
   assign bus.bank_full   = bank_full_q;
   assign bus.frame_count = frame_count_q;

   assign wr_acc    = bus.in_valid && bus.in_ready;
   assign out_acc   = out_valid_q && bus.out_ready;
   assign last_word = (raddr_q == LAST);

   always_comb begin
      rd_en    = 1'b0;
      rd_addr  = {rbank_q, {AW{1'b0}}};
      set_full = 2'b00;
      clr_full = 2'b00;
      if (wr_acc && waddr_q == LAST) set_full[wbank_q] = 1'b1;
      case (state_q)
         R_IDLE: if (bank_full_q[rbank_q]) rd_en = 1'b1;
         // Prefetch the next word while the high byte is on the output.
         R_LO: if (out_acc && !last_word) begin
            rd_en   = 1'b1;
            rd_addr = {rbank_q, raddr_q + AW'(1)};
         end
         R_HI: if (out_acc && last_word) clr_full[rbank_q] = 1'b1;
         default: ;
      endcase
      bank_full_d = (bank_full_q | set_full) & ~clr_full;
   end

   // Reader only touches full banks and writer only non-full ones, so the
   // two ports never collide on an address.
   always_ff @(posedge clock) begin
      if (wr_acc) mem[{wbank_q, waddr_q}] <= bus.in_data;
      if (rd_en)  word_q <= mem[rd_addr];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= R_IDLE;
         wbank_q       <= 1'b0;
         rbank_q       <= 1'b0;
         waddr_q       <= '0;
         raddr_q       <= '0;
         bank_full_q   <= 2'b00;
         out_data_q    <= 8'h00;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         frame_count_q <= 8'h00;
      end else begin
         bank_full_q <= bank_full_d;
         if (wr_acc) begin
            waddr_q <= waddr_q + AW'(1);
            if (waddr_q == LAST) wbank_q <= ~wbank_q;
         end
         case (state_q)
            R_IDLE: if (bank_full_q[rbank_q]) state_q <= R_WAIT;
            R_WAIT: begin
               out_data_q  <= word_q[7:0];
               out_valid_q <= 1'b1;
               state_q     <= R_LO;
            end
            R_LO: if (out_acc) begin
               out_data_q <= word_q[15:8];
               out_last_q <= last_word;
               state_q    <= R_HI;
            end
            R_HI: if (out_acc) begin
               out_last_q <= 1'b0;
               if (!last_word) begin
                  out_data_q <= word_q[7:0];
                  raddr_q    <= raddr_q + AW'(1);
                  state_q    <= R_LO;
               end else begin
                  out_valid_q   <= 1'b0;
                  rbank_q       <= ~rbank_q;
                  raddr_q       <= '0;
                  frame_count_q <= frame_count_q + 8'd1;
                  state_q       <= R_IDLE;
               end
            end
            default: state_q <= R_IDLE;
         endcase
      end
   end
endmodule
